// File: rtl/aha_prog_clk_divider_if.sv
// Bundle of control/status signals for the programmable clock divider.
// The DIV_CE pulse output exists only when AHA_CLKDIV_CE_EN is defined.
interface aha_prog_clk_divider_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  logic [NUM_CH-1:0]       EN;
  logic [NUM_CH-1:0]       CFG_REQ;
  logic [NUM_CH*DIV_W-1:0] CFG_DIV;
  logic [NUM_CH-1:0]       CFG_ACK;
  logic [NUM_CH-1:0]       ACTIVE;
  logic [NUM_CH-1:0]       DIV_CLK;
`ifdef AHA_CLKDIV_CE_EN
  logic [NUM_CH-1:0]       DIV_CE;

  modport master (output EN, CFG_REQ, CFG_DIV, input CFG_ACK, ACTIVE, DIV_CLK, DIV_CE);
  modport slave  (input EN, CFG_REQ, CFG_DIV, output CFG_ACK, ACTIVE, DIV_CLK, DIV_CE);
`else
  modport master (output EN, CFG_REQ, CFG_DIV, input CFG_ACK, ACTIVE, DIV_CLK);
  modport slave  (input EN, CFG_REQ, CFG_DIV, output CFG_ACK, ACTIVE, DIV_CLK);
`endif
endinterface

// File: rtl/aha_prog_clk_divider.sv
// Multi-channel glitch-free 50%-duty clock divider, period 2*(div+1) CLK cycles.
// Define AHA_CLKDIV_CE_EN to add the registered DIV_CE pre-rise pulse output.
//
//  state  | meaning
//  IDLE   | stopped, DIV_CLK low, divide updates applied immediately
//  RUN    | dividing, updates deferred to the next period boundary
//  STOP   | EN dropped, finishing the current period before going IDLE
module aha_prog_clk_divider #(
  parameter int          NUM_CH    = 4,
  parameter int          DIV_W     = 8,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  aha_prog_clk_divider_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t            state_q    [NUM_CH];
  state_t            state_d    [NUM_CH];
  logic [DIV_W-1:0]  cnt_q      [NUM_CH];
  logic [DIV_W-1:0]  cnt_d      [NUM_CH];
  logic [DIV_W-1:0]  div_cur_q  [NUM_CH];
  logic [DIV_W-1:0]  div_cur_d  [NUM_CH];
  logic [DIV_W-1:0]  div_pend_q [NUM_CH];
  logic [DIV_W-1:0]  div_pend_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_r_q, clk_r_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] wrap, rise, active;
`ifdef AHA_CLKDIV_CE_EN
  logic [NUM_CH-1:0] ce_q, ce_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    clk_r_d    = clk_r_q;
    ack_d      = '0;
    wrap       = '0;
    rise       = '0;
    active     = '0;
`ifdef AHA_CLKDIV_CE_EN
    ce_d       = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (state_q[i] != S_IDLE);
      wrap[i]   = (cnt_q[i] == div_cur_q[i]);
      rise[i]   = wrap[i] && !clk_r_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          clk_r_d[i] = 1'b0;
          cnt_d[i]   = '0;
          // a leftover pending value (REQ on the edge into IDLE) is applied here
          if (bus.CFG_REQ[i]) begin
            div_cur_d[i] = bus.CFG_DIV[i*DIV_W +: DIV_W];
            pend_d[i]    = 1'b0;
            ack_d[i]     = 1'b1;
          end else if (pend_q[i]) begin
            div_cur_d[i] = div_pend_q[i];
            pend_d[i]    = 1'b0;
            ack_d[i]     = 1'b1;
          end
          if (bus.EN[i]) begin
            state_d[i] = S_RUN;
            clk_r_d[i] = 1'b1;
          end
        end
        default: begin
          if (wrap[i]) begin
            cnt_d[i]   = '0;
            clk_r_d[i] = ~clk_r_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
          end
          if (rise[i] && pend_q[i]) begin
            div_cur_d[i] = div_pend_q[i];
            pend_d[i]    = 1'b0;
            ack_d[i]     = 1'b1;
          end
          // a request on the boundary edge waits for the following boundary
          if (bus.CFG_REQ[i]) begin
            div_pend_d[i] = bus.CFG_DIV[i*DIV_W +: DIV_W];
            pend_d[i]     = 1'b1;
          end
          if (bus.EN[i]) begin
            state_d[i] = S_RUN;
          end else if (state_q[i] == S_STOP && rise[i]) begin
            state_d[i] = S_IDLE;
            clk_r_d[i] = 1'b0;
          end else begin
            state_d[i] = S_STOP;
          end
        end
      endcase
`ifdef AHA_CLKDIV_CE_EN
      // flag the last low cycle of a period that will rise (STOP rises are suppressed)
      ce_d[i] = (state_d[i] == S_RUN) && !clk_r_d[i] && (cnt_d[i] == div_cur_d[i]);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= S_IDLE;
        cnt_q[i]      <= '0;
        div_cur_q[i]  <= DIV_W'(RESET_DIV);
        div_pend_q[i] <= '0;
      end
      pend_q  <= '0;
      clk_r_q <= '0;
      ack_q   <= '0;
`ifdef AHA_CLKDIV_CE_EN
      ce_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_r_q    <= clk_r_d;
      ack_q      <= ack_d;
`ifdef AHA_CLKDIV_CE_EN
      ce_q       <= ce_d;
`endif
    end
  end

  assign bus.DIV_CLK = clk_r_q;
  assign bus.CFG_ACK = ack_q;
  assign bus.ACTIVE  = active;
`ifdef AHA_CLKDIV_CE_EN
  assign bus.DIV_CE  = ce_q;
`endif

endmodule

// File: tb/tb_aha_prog_clk_divider.sv
// Directed bench for aha_prog_clk_divider (NUM_CH=4, DIV_W=8, RESET_DIV=0).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_aha_prog_clk_divider;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  aha_prog_clk_divider_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  aha_prog_clk_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(0)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // check n consecutive cycles of one channel; patterns are MSB-first
  task automatic run_expect(input string tag, input int ch, input int n,
                            input logic [31:0] clk_pat, input logic [31:0] ack_pat,
                            input logic [31:0] act_pat);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s_clk[%0d]", tag, k), 32'(bus.DIV_CLK[ch]), 32'(clk_pat[n-1-k]));
      chk($sformatf("%s_ack[%0d]", tag, k), 32'(bus.CFG_ACK[ch]), 32'(ack_pat[n-1-k]));
      chk($sformatf("%s_act[%0d]", tag, k), 32'(bus.ACTIVE[ch]),  32'(act_pat[n-1-k]));
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.EN      = '0;
    bus.CFG_REQ = '0;
    bus.CFG_DIV = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_clk", 32'(bus.DIV_CLK), 32'h0);
    chk("rst_act", 32'(bus.ACTIVE),  32'h0);
    chk("rst_ack", 32'(bus.CFG_ACK), 32'h0);
`ifdef AHA_CLKDIV_CE_EN
    chk("rst_ce",  32'(bus.DIV_CE),  32'h0);
`endif
    rst = 1'b0;
  endtask

  task automatic req(input int ch, input logic [DIV_W-1:0] div);
    bus.CFG_REQ[ch]                = 1'b1;
    bus.CFG_DIV[ch*DIV_W +: DIV_W] = div;
  endtask

  initial begin
    int hi, lo, ce_cnt, ce_at;
    n_checks = 0;
    n_fail   = 0;

    // 1: divide by 2 from reset value
    do_reset();
    bus.EN[0] = 1'b1;
    run_expect("t1", 0, 6, 6'b101010, 6'b000000, 6'b111111);

    // 2: idle update of ch1 to div 3, then run (4H/4L)
    do_reset();
    req(1, 8'd3);
    @(negedge clk);
    bus.CFG_REQ = '0;
    chk("t2_idle_ack", 32'(bus.CFG_ACK[1]), 32'h1);
    bus.EN[1] = 1'b1;
    run_expect("t2", 1, 8, 8'b11110000, 8'b00000000, 8'b11111111);

    // 3: update to div 1 in second high cycle; current period stays 8
    run_expect("t3a", 1, 2, 2'b11, 2'b00, 2'b11);
    req(1, 8'd1);
    run_expect("t3b", 1, 1, 1'b1, 1'b0, 1'b1);
    bus.CFG_REQ = '0;
    run_expect("t3c", 1, 10, 10'b1000011001, 10'b0000010000, 10'b1111111111);

    // 4: ch0 div 2, drop EN in high phase, then stop/restart seamlessly
    do_reset();
    req(0, 8'd2);
    @(negedge clk);
    bus.CFG_REQ = '0;
    chk("t4_idle_ack", 32'(bus.CFG_ACK[0]), 32'h1);
    bus.EN[0] = 1'b1;
    run_expect("t4a", 0, 2, 2'b11, 2'b00, 2'b11);
    bus.EN[0] = 1'b0;
    run_expect("t4b", 0, 7, 7'b1000000, 7'b0000000, 7'b1111000);
    bus.EN[0] = 1'b1;
    run_expect("t4c", 0, 1, 1'b1, 1'b0, 1'b1);
    bus.EN[0] = 1'b0;
    run_expect("t4d", 0, 3, 3'b110, 3'b000, 3'b111);
    bus.EN[0] = 1'b1;
    run_expect("t4e", 0, 6, 6'b001110, 6'b000000, 6'b111111);

    // 5: reset mid-high with an update pending
    do_reset();
    req(2, 8'd3);
    @(negedge clk);
    bus.CFG_REQ = '0;
    bus.EN[2]   = 1'b1;
    @(negedge clk);
    chk("t5_run_clk", 32'(bus.DIV_CLK[2]), 32'h1);
    req(2, 8'd5);
    @(negedge clk);
    bus.CFG_REQ = '0;
    rst         = 1'b1;
    @(negedge clk);
    chk("t5_rst_clk", 32'(bus.DIV_CLK[2]), 32'h0);
    chk("t5_rst_act", 32'(bus.ACTIVE[2]),  32'h0);
    chk("t5_rst_ack", 32'(bus.CFG_ACK[2]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_expect("t5", 2, 4, 4'b1010, 4'b0000, 4'b1111);

    // 6: maximum divide, period 512
    do_reset();
    req(3, 8'd255);
    @(negedge clk);
    bus.CFG_REQ = '0;
    bus.EN[3]   = 1'b1;
    hi = 0; lo = 0; ce_cnt = 0; ce_at = -1;
    for (int k = 0; k <= 512; k++) begin
      @(negedge clk);
      if (k < 256 && bus.DIV_CLK[3]) hi++;
      if (k >= 256 && k < 512 && !bus.DIV_CLK[3]) lo++;
      if (k == 512) chk("t6_rise", 32'(bus.DIV_CLK[3]), 32'h1);
`ifdef AHA_CLKDIV_CE_EN
      if (bus.DIV_CE[3]) begin
        ce_cnt++;
        ce_at = k;
      end
`endif
    end
    chk("t6_high_len", 32'(hi), 32'd256);
    chk("t6_low_len",  32'(lo), 32'd256);
`ifdef AHA_CLKDIV_CE_EN
    chk("t6_ce_cnt", 32'(ce_cnt), 32'd1);
    chk("t6_ce_at",  32'(ce_at),  32'd511);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
